// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. It drives the
// stall/flush enables of the fetch, decode, exec, mem and writeback pipeline
// registers and the exec-stage forwarding selects. It sequences three kinds
// of event:
//   - multi-cycle FPU ops held in exec (FPU_WAIT),
//   - `in` instructions in mem waiting on receive data (IN_WAIT),
//   - load-use and taken-branch hazards.
// The only sequential state is the FSM state plus the FPU down-counter `cnt`.
//
// Optional feature: define HAZARD_PERF_EN to enable the two 32-bit wrapping
// performance counters. When it is undefined the perf ports still exist but
// are tied to zero and no counter logic is built.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int FPU_LAT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   // decode stage sources, {is_fp, idx}
   input  logic [5:0]           d_rs1,
   input  logic [5:0]           d_rs2,
   input  logic                 d_use_rs1,
   input  logic                 d_use_rs2,
   // exec stage
   input  logic [5:0]           e_rs1,
   input  logic [5:0]           e_rs2,
   input  logic [5:0]           e_rd,
   input  logic                 e_reg_write,
   input  logic                 e_is_load,
   input  logic                 e_pc_src,
   input  logic                 e_fpu_multi,
   input  logic [FPU_LAT_W-1:0] e_fpu_lat,
   // mem stage
   input  logic [5:0]           m_rd,
   input  logic                 m_reg_write,
   input  logic                 m_is_in,
   input  logic                 in_valid,
   // writeback stage
   input  logic [5:0]           w_rd,
   input  logic                 w_reg_write,
   // pipeline register controls
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_m,
   output logic                 flush_w,
   // exec operand forwarding selects
   output logic [1:0]           fwd_a_e,
   output logic [1:0]           fwd_b_e,
   // sequencing handshakes
   output logic                 fpu_start,
   output logic                 in_ack,
   output logic                 busy,
   // performance counters
   output logic [31:0]          perf_stall_cycles,
   output logic [31:0]          perf_flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FPU_WAIT = 2'd1,
      IN_WAIT  = 2'd2
   } state_t;

   // int x0 is hard-wired zero and never takes part in a hazard or forward.
   localparam logic [5:0]           REG_X0  = 6'h00;
   localparam logic [FPU_LAT_W-1:0] LAT_ONE = FPU_LAT_W'(1);
   localparam logic [FPU_LAT_W-1:0] LAT_TWO = FPU_LAT_W'(2);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   state_t               state;
   state_t               state_nxt;
   logic [FPU_LAT_W-1:0] cnt;
   logic [FPU_LAT_W-1:0] cnt_nxt;

   // ---------------------------------------------------------------------------
   // Hazard decode
   // ---------------------------------------------------------------------------
   logic in_blocked;   // `in` in mem with no receive data yet
   logic fpu_long;     // exec FPU op needs the pipeline held (L >= 2)
   logic rs1_dep;
   logic rs2_dep;
   logic load_use;

   assign in_blocked = m_is_in & ~in_valid;
   assign fpu_long   = e_fpu_lat > LAT_ONE;
   assign rs1_dep    = d_use_rs1 & (d_rs1 == e_rd);
   assign rs2_dep    = d_use_rs2 & (d_rs2 == e_rd);
   assign load_use   = e_is_load & e_reg_write & (e_rd != REG_X0) & (rs1_dep | rs2_dep);

   // ---------------------------------------------------------------------------
   // Sequencing: decide stalls, flushes, handshakes and next state/counter.
   // Priority is IN wait, then FPU wait, then branch flush, then load-use.
   // ---------------------------------------------------------------------------
   logic issue_ok;     // exec instruction may launch an FPU op this cycle

   // Control decision for the current cycle, purely from inputs and state.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case/if tree leaves one unassigned and no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      flush_w   = 1'b0;
      fpu_start = 1'b0;
      in_ack    = 1'b0;
      issue_ok  = 1'b0;

      case (state)
         IN_WAIT: begin
            if (in_valid) begin
               // Data arrived: consume it, release mem, and let exec proceed
               // (which may launch an FPU op that was waiting behind the `in`).
               in_ack    = 1'b1;
               issue_ok  = 1'b1;
               state_nxt = RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
            end
         end

         FPU_WAIT: begin
            if (cnt != '0) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
               cnt_nxt = cnt - LAT_ONE;
            end else begin
               // Last exec cycle of the FPU op: exec is released and the op
               // already in flight must not be launched a second time.
               state_nxt = RUN;
            end
         end

         default: begin  // RUN
            if (in_blocked) begin
               stall_f   = 1'b1;
               stall_d   = 1'b1;
               stall_e   = 1'b1;
               stall_m   = 1'b1;
               flush_w   = 1'b1;
               state_nxt = IN_WAIT;
            end else begin
               in_ack   = m_is_in;
               issue_ok = 1'b1;
            end
         end
      endcase

      // FPU launch: one start pulse; ops of latency 2 or more hold exec and
      // count down the remaining L-2 stall cycles in FPU_WAIT.
      if (issue_ok && e_fpu_multi) begin
         fpu_start = 1'b1;
         if (fpu_long) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            flush_m   = 1'b1;
            cnt_nxt   = e_fpu_lat - LAT_TWO;
            state_nxt = FPU_WAIT;
         end
      end

      // Branch and load-use only matter when exec is actually advancing.
      // A taken branch squashes decode, which removes any load-use consumer.
      if (!stall_e) begin
         if (e_pc_src) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Forwarding into exec: mem beats writeback; an `in` in mem has no result
   // until its data is acknowledged.
   // ---------------------------------------------------------------------------
   logic mem_fwd_ok;
   logic wb_fwd_ok;

   assign mem_fwd_ok = m_reg_write & (m_rd != REG_X0) & ~(m_is_in & ~in_ack);
   assign wb_fwd_ok  = w_reg_write & (w_rd != REG_X0);

   // Operand A/B forwarding select from the mem and writeback destinations.
   always_comb begin
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;

      if (mem_fwd_ok && (m_rd == e_rs1)) begin
         fwd_a_e = FWD_MEM;
      end else if (wb_fwd_ok && (w_rd == e_rs1)) begin
         fwd_a_e = FWD_WB;
      end

      if (mem_fwd_ok && (m_rd == e_rs2)) begin
         fwd_b_e = FWD_MEM;
      end else if (wb_fwd_ok && (w_rd == e_rs2)) begin
         fwd_b_e = FWD_WB;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------

   // FSM state and FPU countdown; reset returns to RUN from any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before the edge, independent of statement order.
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign busy = (state != RUN);

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
   // Count front-end stall cycles and flush events; both wrap at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (stall_f) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (flush_d || flush_e) begin
            perf_flush_count <= perf_flush_count + 32'd1;
         end
      end
   end
`else
   assign perf_stall_cycles = '0;
   assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a behavioural model of the controller. The model thinks in
// terms of "an `in` is pending" and "the FPU op still owns exec for N more
// cycles" rather than FSM states. Inputs change on the falling edge; outputs
// are checked shortly after, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int FPU_LAT_W = 4;

`ifdef HAZARD_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [5:0]           d_rs1, d_rs2;
   logic                 d_use_rs1, d_use_rs2;
   logic [5:0]           e_rs1, e_rs2, e_rd;
   logic                 e_reg_write, e_is_load, e_pc_src, e_fpu_multi;
   logic [FPU_LAT_W-1:0] e_fpu_lat;
   logic [5:0]           m_rd;
   logic                 m_reg_write, m_is_in, in_valid;
   logic [5:0]           w_rd;
   logic                 w_reg_write;
   logic                 stall_f, stall_d, stall_e, stall_m;
   logic                 flush_d, flush_e, flush_m, flush_w;
   logic [1:0]           fwd_a_e, fwd_b_e;
   logic                 fpu_start, in_ack, busy;
   logic [31:0]          perf_stall_cycles, perf_flush_count;

   hazard_ctrl #(.FPU_LAT_W(FPU_LAT_W)) dut (
      .clk(clk), .rst(rst),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
      .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
      .e_reg_write(e_reg_write), .e_is_load(e_is_load), .e_pc_src(e_pc_src),
      .e_fpu_multi(e_fpu_multi), .e_fpu_lat(e_fpu_lat),
      .m_rd(m_rd), .m_reg_write(m_reg_write), .m_is_in(m_is_in), .in_valid(in_valid),
      .w_rd(w_rd), .w_reg_write(w_reg_write),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
      .fpu_start(fpu_start), .in_ack(in_ack), .busy(busy),
      .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Expected outputs for the current cycle.
   typedef struct packed {
      logic        stall_f, stall_d, stall_e, stall_m;
      logic        flush_d, flush_e, flush_m, flush_w;
      logic [1:0]  fwd_a, fwd_b;
      logic        fpu_start, in_ack, busy;
      logic [31:0] perf_stall, perf_flush;
   } exp_t;

   exp_t        ex;
   // Reference model state.
   bit          in_pending;     // an `in` sits in mem waiting for data
   int          fpu_own;        // further cycles the launched FPU op owns exec
   int unsigned perf_stall_m;
   int unsigned perf_flush_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [5:0] rs, input bit mem_has_result);
      if (mem_has_result && m_reg_write && m_rd != 6'h00 && m_rd == rs) return 2'b10;
      if (w_reg_write && w_rd != 6'h00 && w_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      in_pending   = 1'b0;
      fpu_own      = 0;
      perf_stall_m = 0;
      perf_flush_m = 0;
   endtask

   // Expected outputs from the current inputs and model state.
   task automatic model_expect();
      bit may_issue;
      bit dep;
      ex        = '0;
      may_issue = 1'b0;
      if (in_pending) begin
         if (in_valid) begin
            ex.in_ack = 1'b1;
            may_issue = 1'b1;
         end else begin
            {ex.stall_f, ex.stall_d, ex.stall_e, ex.stall_m, ex.flush_w} = 5'b11111;
         end
      end else if (fpu_own > 1) begin
         {ex.stall_f, ex.stall_d, ex.stall_e, ex.flush_m} = 4'b1111;
      end else if (fpu_own == 1) begin
         // final exec cycle of an FPU op: no hold, no new launch
      end else if (m_is_in && !in_valid) begin
         {ex.stall_f, ex.stall_d, ex.stall_e, ex.stall_m, ex.flush_w} = 5'b11111;
      end else begin
         ex.in_ack = m_is_in;
         may_issue = 1'b1;
      end
      if (may_issue && e_fpu_multi) begin
         ex.fpu_start = 1'b1;
         if (int'(e_fpu_lat) >= 2) {ex.stall_f, ex.stall_d, ex.stall_e, ex.flush_m} = 4'b1111;
      end
      if (!ex.stall_e) begin
         dep = (d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd);
         if (e_pc_src) begin
            ex.flush_d = 1'b1;
            ex.flush_e = 1'b1;
         end else if (e_is_load && e_reg_write && e_rd != 6'h00 && dep) begin
            ex.stall_f = 1'b1;
            ex.stall_d = 1'b1;
            ex.flush_e = 1'b1;
         end
      end
      ex.fwd_a      = fwd_ref(e_rs1, !(m_is_in && !ex.in_ack));
      ex.fwd_b      = fwd_ref(e_rs2, !(m_is_in && !ex.in_ack));
      ex.busy       = in_pending || (fpu_own > 0);
      ex.perf_stall = PERF_EN ? perf_stall_m : 32'd0;
      ex.perf_flush = PERF_EN ? perf_flush_m : 32'd0;
   endtask

   // Model state update at the rising edge.
   task automatic model_advance();
      if (rst) begin
         model_reset();
      end else begin
         if (ex.stall_f) perf_stall_m++;
         if (ex.flush_d || ex.flush_e) perf_flush_m++;
         if (in_pending) begin
            if (in_valid) in_pending = 1'b0;
         end else if (fpu_own > 0) begin
            fpu_own--;
         end else if (m_is_in && !in_valid) begin
            in_pending = 1'b1;
         end
         // An op of latency L owns exec for L cycles, this one included.
         if (ex.fpu_start && int'(e_fpu_lat) >= 2) fpu_own = int'(e_fpu_lat) - 1;
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".stall_f"},   32'(stall_f),   32'(ex.stall_f));
      chk({tag, ".stall_d"},   32'(stall_d),   32'(ex.stall_d));
      chk({tag, ".stall_e"},   32'(stall_e),   32'(ex.stall_e));
      chk({tag, ".stall_m"},   32'(stall_m),   32'(ex.stall_m));
      chk({tag, ".flush_d"},   32'(flush_d),   32'(ex.flush_d));
      chk({tag, ".flush_e"},   32'(flush_e),   32'(ex.flush_e));
      chk({tag, ".flush_m"},   32'(flush_m),   32'(ex.flush_m));
      chk({tag, ".flush_w"},   32'(flush_w),   32'(ex.flush_w));
      chk({tag, ".fwd_a_e"},   32'(fwd_a_e),   32'(ex.fwd_a));
      chk({tag, ".fwd_b_e"},   32'(fwd_b_e),   32'(ex.fwd_b));
      chk({tag, ".fpu_start"}, 32'(fpu_start), 32'(ex.fpu_start));
      chk({tag, ".in_ack"},    32'(in_ack),    32'(ex.in_ack));
      chk({tag, ".busy"},      32'(busy),      32'(ex.busy));
      chk({tag, ".perf_stall"}, perf_stall_cycles, ex.perf_stall);
      chk({tag, ".perf_flush"}, perf_flush_count,  ex.perf_flush);
   endtask

   // Called just after a falling edge once inputs are set.
   task automatic settle_check(input string tag);
      #1;
      if (rst) model_reset();
      model_expect();
      compare_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic idle();
      {d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd} = '0;
      {d_use_rs1, d_use_rs2, e_reg_write, e_is_load, e_pc_src, e_fpu_multi} = '0;
      e_fpu_lat = '0;
      {m_reg_write, m_is_in, in_valid, w_reg_write} = '0;
   endtask

   function automatic logic [5:0] pick_reg();
      case ($urandom_range(0, 5))
         0:       return 6'h00;
         1:       return 6'h01;
         2:       return 6'h05;
         3:       return 6'h20;
         4:       return 6'h21;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      model_reset();
      idle();
      rst = 1'b1;
      @(negedge clk);

      // ---- reset state ----
      settle_check("reset");
      chk("reset.busy_const", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      settle_check("idle");
      tick();

      // ---- load-use: lw x5 in exec, decode reads x5 ----
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 6'd5;
      d_rs1 = 6'd5; d_use_rs1 = 1'b1;
      settle_check("lu");
      chk("lu.stall_d_const", 32'(stall_d), 32'd1);
      chk("lu.flush_e_const", 32'(flush_e), 32'd1);
      tick();
      idle();                                   // bubble in exec, load in mem
      m_rd = 6'd5; m_reg_write = 1'b1;
      settle_check("lu_bubble");
      tick();
      idle();                                   // load in wb, consumer in exec
      w_rd = 6'd5; w_reg_write = 1'b1; e_rs1 = 6'd5;
      settle_check("lu_fwd");
      chk("lu_fwd.fwd_a_const", 32'(fwd_a_e), 32'd1);
      tick();

      // ---- same load with rd = x0: no stall ----
      idle();
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 6'd0; d_rs1 = 6'd0; d_use_rs1 = 1'b1;
      settle_check("lu_x0");
      chk("lu_x0.stall_d_const", 32'(stall_d), 32'd0);
      tick();

      // ---- fp f0 is a real register ----
      idle();
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 6'h20; d_rs2 = 6'h20; d_use_rs2 = 1'b1;
      settle_check("lu_f0");
      tick();

      // ---- mem beats writeback on operand B ----
      idle();
      m_rd = 6'd3; m_reg_write = 1'b1; w_rd = 6'd3; w_reg_write = 1'b1; e_rs2 = 6'd3;
      settle_check("fwd_prio");
      chk("fwd_prio.fwd_b_const", 32'(fwd_b_e), 32'd2);
      tick();

      // ---- fdiv L=5: start 1 cycle, stall 4, busy 4, released on cycle 5 ----
      idle();
      e_fpu_multi = 1'b1; e_fpu_lat = 4'd5;
      for (int i = 0; i < 5; i++) begin
         settle_check($sformatf("fdiv5_c%0d", i));
         chk($sformatf("fdiv5_c%0d.stall_e_const", i), 32'(stall_e), 32'(i < 4));
         chk($sformatf("fdiv5_c%0d.busy_const", i), 32'(busy), 32'(i > 0));
         tick();
      end
      idle();
      settle_check("fdiv5_after");
      tick();

      // ---- L=1 and L=0: launch only ----
      for (int l = 0; l < 2; l++) begin
         idle();
         e_fpu_multi = 1'b1; e_fpu_lat = 4'(l);
         settle_check($sformatf("fpu_l%0d", l));
         chk($sformatf("fpu_l%0d.stall_e_const", l), 32'(stall_e), 32'd0);
         tick();
      end

      // ---- `in` in mem, data 3 cycles later ----
      idle();
      m_is_in = 1'b1; m_reg_write = 1'b1; m_rd = 6'd7; e_rs1 = 6'd7;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i == 3);
         settle_check($sformatf("in_c%0d", i));
         chk($sformatf("in_c%0d.stall_m_const", i), 32'(stall_m), 32'(i < 3));
         chk($sformatf("in_c%0d.in_ack_const", i), 32'(in_ack), 32'(i == 3));
         tick();
      end

      // ---- `in` waiting while fdiv L=4 sits in exec ----
      idle();
      m_is_in = 1'b1; e_fpu_multi = 1'b1; e_fpu_lat = 4'd4;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) in_valid = 1'b1;
         if (i == 3) begin m_is_in = 1'b0; in_valid = 1'b0; end
         settle_check($sformatf("in_fpu_c%0d", i));
         chk($sformatf("in_fpu_c%0d.fpu_start_const", i), 32'(fpu_start), 32'(i == 2));
         tick();
      end

      // ---- taken branch with a load-use hazard present ----
      idle();
      e_pc_src = 1'b1; e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 6'd9;
      d_rs1 = 6'd9; d_use_rs1 = 1'b1;
      settle_check("br_lu");
      chk("br_lu.stall_d_const", 32'(stall_d), 32'd0);
      chk("br_lu.flush_d_const", 32'(flush_d), 32'd1);
      tick();

      // ---- reset mid FPU_WAIT (counter at 2) ----
      idle();
      e_fpu_multi = 1'b1; e_fpu_lat = 4'd5;
      settle_check("rst_fpu_launch");
      tick();
      settle_check("rst_fpu_wait");
      tick();
      settle_check("rst_fpu_wait2");
      chk("rst_fpu_wait2.busy_const", 32'(busy), 32'd1);
      idle();
      rst = 1'b1;
      settle_check("rst_mid");
      chk("rst_mid.stall_e_const", 32'(stall_e), 32'd0);
      chk("rst_mid.busy_const", 32'(busy), 32'd0);
      chk("rst_mid.perf_stall_const", perf_stall_cycles, 32'd0);
      tick();
      rst = 1'b0;
      settle_check("rst_after");
      tick();

      // ---- randomized traffic ----
      for (int n = 0; n < 800; n++) begin
         rst         = ($urandom_range(0, 99) == 0);
         d_rs1       = pick_reg();
         d_rs2       = pick_reg();
         d_use_rs1   = 1'($urandom_range(0, 1));
         d_use_rs2   = 1'($urandom_range(0, 1));
         e_rs1       = pick_reg();
         e_rs2       = pick_reg();
         e_rd        = pick_reg();
         e_reg_write = ($urandom_range(0, 3) != 0);
         e_is_load   = ($urandom_range(0, 2) == 0);
         e_pc_src    = ($urandom_range(0, 5) == 0);
         e_fpu_multi = ($urandom_range(0, 7) == 0);
         e_fpu_lat   = 4'($urandom_range(0, 7));
         m_rd        = pick_reg();
         m_reg_write = 1'($urandom_range(0, 1));
         m_is_in     = ($urandom_range(0, 5) == 0);
         in_valid    = 1'($urandom_range(0, 1));
         w_rd        = pick_reg();
         w_reg_write = 1'($urandom_range(0, 1));
         settle_check($sformatf("rand%0d", n));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
